// File: rtl/decode_pkg.sv
// decode_pkg: shared RV32IM opcode, funct and encoding constants for the decode stage.
package decode_pkg;
    localparam int INSTRUCTION_WIDTH = 32;
    localparam int DATA_WIDTH        = 32;
    localparam int REGADDR_WIDTH     = 5;
    localparam int RESLT_SELCT_WIDTH = 3;

    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP        = 7'h33;
    localparam logic [6:0] OP_JAL    = 7'h6f;
    localparam logic [6:0] OP_BRANCH = 7'h63;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_SUB    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    typedef enum logic [2:0] {
        RS_ADD = 3'd0,
        RS_MUL = 3'd1,
        RS_DIV = 3'd2,
        RS_REM = 3'd3,
        RS_SLT = 3'd6
    } result_sel_e;

    typedef enum logic [2:0] {
        BR_NONE, BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU
    } branch_e;

    // funct3 0/1 -> BEQ/BNE, 4..7 -> BLT..BGEU; 2/3 are rejected by the decoder
    function automatic branch_e branch_of(input logic [2:0] f3);
        return f3[2] ? branch_e'(3'(f3[1:0]) + 3'd3) : branch_e'(3'(f3[0]) + 3'd1);
    endfunction
endpackage

// File: rtl/decode_stage_instr_decode_comb.sv
// instr_decode_comb: combinational RV32IM subset decoder, instruction word to execute control bundle.
module instr_decode_comb #(
    parameter int INSTRUCTION_WIDTH = decode_pkg::INSTRUCTION_WIDTH,
    parameter int DATA_WIDTH        = decode_pkg::DATA_WIDTH,
    parameter int REGADDR_WIDTH     = decode_pkg::REGADDR_WIDTH,
    parameter int RESLT_SELCT_WIDTH = decode_pkg::RESLT_SELCT_WIDTH
) (
    input  logic [INSTRUCTION_WIDTH-1:0] instr_i,
    output logic [REGADDR_WIDTH-1:0]     a_location_o,
    output logic [REGADDR_WIDTH-1:0]     b_location_o,
    output logic [REGADDR_WIDTH-1:0]     write_select_o,
    output logic                         immediate_select_o,
    output logic                         unsigned_select_o,
    output logic                         subtract_enable_o,
    output logic                         write_enable_o,
    output logic                         pc_overwrite_o,
    output logic                         jump_instruction_o,
    output logic                         error_o,
    output logic [DATA_WIDTH-1:0]        immediate_val_o,
    output logic [RESLT_SELCT_WIDTH-1:0] result_select_o,
    output logic [2:0]                   branch_type_o
);
    import decode_pkg::*;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic legal, imm_sel, uns, sub, jump;
    result_sel_e rs;
    branch_e br;
    logic [DATA_WIDTH-1:0] imm, imm_i, imm_b, imm_j;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign imm_i  = {{(DATA_WIDTH-12){instr_i[31]}}, instr_i[31:20]};
    assign imm_b  = {{(DATA_WIDTH-13){instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_j  = {{(DATA_WIDTH-21){instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    always_comb begin
        legal   = 1'b0;
        imm_sel = 1'b0;
        uns     = 1'b0;
        sub     = 1'b0;
        jump    = 1'b0;
        rs      = RS_ADD;
        br      = BR_NONE;
        imm     = '0;
        case (opcode)
            OP_IMM: begin
                legal   = funct3 == F3_ADD || funct3 == F3_SLT || funct3 == F3_SLTU;
                imm_sel = 1'b1;
                imm     = imm_i;
                uns     = funct3 == F3_SLTU;
                rs      = funct3 == F3_ADD ? RS_ADD : RS_SLT;
            end
            OP: begin
                if (funct7 == F7_BASE) begin
                    legal = funct3 == F3_ADD || funct3 == F3_SLT || funct3 == F3_SLTU;
                    uns   = funct3 == F3_SLTU;
                    rs    = funct3 == F3_ADD ? RS_ADD : RS_SLT;
                end else if (funct7 == F7_SUB) begin
                    legal = funct3 == F3_ADD;
                    sub   = 1'b1;
                end else if (funct7 == F7_MULDIV) begin
                    legal = funct3 == F3_ADD || funct3[2];
                    uns   = funct3[2] && funct3[0];
                    rs    = funct3 == F3_ADD ? RS_MUL : (funct3[1] ? RS_REM : RS_DIV);
                end
            end
            OP_JAL: begin
                legal   = 1'b1;
                imm_sel = 1'b1;
                imm     = imm_j;
                jump    = 1'b1;
            end
            OP_BRANCH: begin
                legal = funct3[2] || !funct3[1];
                imm   = imm_b;
                br    = branch_of(funct3);
                uns   = funct3[2] && funct3[1];
            end
            default: ;
        endcase
    end

    // Rejected encodings still travel down the pipe, but with every side effect masked
    assign a_location_o       = instr_i[15 +: REGADDR_WIDTH];
    assign b_location_o       = instr_i[20 +: REGADDR_WIDTH];
    assign write_select_o     = instr_i[7 +: REGADDR_WIDTH];
    assign error_o            = !legal;
    assign immediate_select_o = legal && imm_sel;
    assign unsigned_select_o  = legal && uns;
    assign subtract_enable_o  = legal && sub;
    assign jump_instruction_o = legal && jump;
    assign write_enable_o     = legal && opcode != OP_BRANCH;
    assign pc_overwrite_o     = legal && (jump || opcode == OP_BRANCH);
    assign branch_type_o      = legal ? br : BR_NONE;
    assign result_select_o    = legal ? RESLT_SELCT_WIDTH'(rs) : '0;
    assign immediate_val_o    = legal ? imm : '0;
endmodule

// File: rtl/decode_stage.sv
// decode_stage: buffered decode stage, circular instruction queue feeding a registered control bundle.
module decode_stage #(
    parameter int INSTRUCTION_WIDTH = decode_pkg::INSTRUCTION_WIDTH,
    parameter int DATA_WIDTH        = decode_pkg::DATA_WIDTH,
    parameter int REGADDR_WIDTH     = decode_pkg::REGADDR_WIDTH,
    parameter int QUEUE_DEPTH       = 4,
    parameter int RESLT_SELCT_WIDTH = decode_pkg::RESLT_SELCT_WIDTH
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               flush,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [INSTRUCTION_WIDTH-1:0]       in_instr,
    input  logic [DATA_WIDTH-1:0]              in_pc,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DATA_WIDTH-1:0]              out_pc,
    output logic [REGADDR_WIDTH-1:0]           a_location,
    output logic [REGADDR_WIDTH-1:0]           b_location,
    output logic [REGADDR_WIDTH-1:0]           writeSelect,
    output logic                               immediateSelect,
    output logic                               unsignedSelect,
    output logic                               subtractEnable,
    output logic                               writeEnable,
    output logic                               pcOverwrite,
    output logic                               jumpInstruction,
    output logic                               error,
    output logic [DATA_WIDTH-1:0]              immediateVal,
    output logic [RESLT_SELCT_WIDTH-1:0]       resultSelect,
    output logic [2:0]                         branchType,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count
);
    import decode_pkg::*;

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam int BW = 2 * DATA_WIDTH + 3 * REGADDR_WIDTH + RESLT_SELCT_WIDTH + 10;
    localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);

    logic [INSTRUCTION_WIDTH-1:0] instr_q [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0]        pc_q    [QUEUE_DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic valid_q, valid_d;
    logic [BW-1:0] bundle_q, bundle_d, dec_bundle;
    logic push, pop;

    logic [REGADDR_WIDTH-1:0] d_a, d_b, d_w;
    logic d_isel, d_uns, d_sub, d_we, d_pco, d_jmp, d_err;
    logic [DATA_WIDTH-1:0] d_imm;
    logic [RESLT_SELCT_WIDTH-1:0] d_rs;
    logic [2:0] d_br;

    assign in_ready = count_q != FULL && !flush;
    assign push     = in_valid && in_ready;
    assign pop      = count_q != '0 && (!valid_q || out_ready) && !flush;

    instr_decode_comb #(
        .INSTRUCTION_WIDTH (INSTRUCTION_WIDTH),
        .DATA_WIDTH        (DATA_WIDTH),
        .REGADDR_WIDTH     (REGADDR_WIDTH),
        .RESLT_SELCT_WIDTH (RESLT_SELCT_WIDTH)
    ) u_dec (
        .instr_i            (instr_q[head_q]),
        .a_location_o       (d_a),
        .b_location_o       (d_b),
        .write_select_o     (d_w),
        .immediate_select_o (d_isel),
        .unsigned_select_o  (d_uns),
        .subtract_enable_o  (d_sub),
        .write_enable_o     (d_we),
        .pc_overwrite_o     (d_pco),
        .jump_instruction_o (d_jmp),
        .error_o            (d_err),
        .immediate_val_o    (d_imm),
        .result_select_o    (d_rs),
        .branch_type_o      (d_br)
    );

    assign dec_bundle = {pc_q[head_q], d_a, d_b, d_w, d_isel, d_uns, d_sub, d_we, d_pco, d_jmp, d_err, d_imm, d_rs, d_br};
    assign {out_pc, a_location, b_location, writeSelect, immediateSelect, unsignedSelect, subtractEnable,
            writeEnable, pcOverwrite, jumpInstruction, error, immediateVal, resultSelect, branchType} = bundle_q;
    assign out_valid   = valid_q;
    assign queue_count = count_q;

    always_comb begin
        head_d   = pop ? head_q + PW'(1) : head_q;
        tail_d   = push ? tail_q + PW'(1) : tail_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        valid_d  = pop ? 1'b1 : (out_ready ? 1'b0 : valid_q);
        bundle_d = pop ? dec_bundle : bundle_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
        end
    end

    // Payload storage needs no reset: occupancy is tracked entirely by count_q
    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[tail_q] <= in_instr;
            pc_q[tail_q]    <= in_pc;
        end
    end
endmodule
